// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ready handshake and presents
// the word to decode under valid/ack. Optional misaligned-PC trap via IFU_MISALIGN_TRAP_EN.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_ins_addr,
  output logic [31:0] ins_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins_out,
  output logic        ins_valid,
  input  logic        ins_ack,
  output logic [31:0] retire_cnt,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {StIdle, StReq, StValid, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, ins_q, cnt_q;
  logic        accept, load_pc;

  assign accept = (state_q == StValid) && ins_ack;

`ifdef IFU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |next_ins_addr[1:0];
  assign load_pc    = accept && !misaligned;
`else
  assign load_pc    = accept;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  state_d = StReq;
      StReq:   if (imem_ready) state_d = StValid;
      StValid: begin
        if (ins_ack) begin
`ifdef IFU_MISALIGN_TRAP_EN
          state_d = misaligned ? StFault : StReq;
`else
          state_d = StReq;
`endif
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    ins_valid   = 1'b0;
    fetch_fault = 1'b0;
    case (state_q)
      StReq:   imem_req  = 1'b1;
      StValid: ins_valid = 1'b1;
`ifdef IFU_MISALIGN_TRAP_EN
      StFault: fetch_fault = 1'b1;
`endif
      default: ;
    endcase
  end

  // Masking is a no-op for aligned targets, so one load path serves both builds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      ins_q <= '0;
      cnt_q <= '0;
    end else begin
      if (state_q == StReq && imem_ready) ins_q <= imem_rdata;
      if (accept) cnt_q <= cnt_q + 32'd1;
      if (load_pc) pc_q <= next_ins_addr & 32'hFFFF_FFFC;
    end
  end

  assign ins_addr   = pc_q;
  assign imem_addr  = pc_q;
  assign ins_out    = ins_q;
  assign retire_cnt = cnt_q;

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch stage of the single-cycle MIPS core. It holds the program counter and drives it as `ins_addr` to the next-PC logic. It fetches the word at that address from instruction memory over a request/ready handshake and presents it to decode under a valid/ack handshake. On ack it loads the `next_ins_addr` computed downstream and counts the retired instruction.

## Interface
- `RESET_PC`, default `32'h0000_3000`: PC value after reset; the text segment base.
- `clk` in 1: the single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `next_ins_addr` in 32: next PC from the next-PC logic; sampled only on the accept cycle.
- `ins_addr` out 32: current PC, the registered PC value.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address; always equals `ins_addr`.
- `imem_ready` in 1: memory has `imem_rdata` valid this cycle; honoured only while `imem_req`=1.
- `imem_rdata` in 32: fetched instruction word.
- `ins_out` out 32: instruction presented to decode (registered).
- `ins_valid` out 1: `ins_out` is valid.
- `ins_ack` in 1: decode/commit accepts `ins_out`; honoured only while `ins_valid`=1.
- `retire_cnt` out 32: number of accepted instructions; wraps modulo 2^32.
- `fetch_fault` out 1: sticky misaligned-PC fault; constant 0 unless the macro in Configuration is defined.

## Operation
- **States:**
  - `IDLE`: one cycle after reset release.
  - `REQ`: request outstanding.
  - `VALID`: instruction held for decode.
  - `FAULT`: only when the macro is defined.
- **Transitions:**
  - `IDLE` → `REQ` unconditionally on the next edge.
  - `REQ`: `imem_req`=1. If `imem_ready`=1, `ins_out` ← `imem_rdata` and go to `VALID`. Otherwise stay in `REQ`; the address is held stable and there is no timeout.
  - `VALID`: `ins_valid`=1, `imem_req`=0. If `ins_ack`=1, then PC ← `next_ins_addr`, `retire_cnt` ← `retire_cnt`+1, and go to `REQ`. Otherwise hold; `ins_out` and `ins_addr` are unchanged.
  - `FAULT`: `imem_req`=0, `ins_valid`=0, `fetch_fault`=1. Left only by reset.
- **Ignored inputs:**
  - `imem_ready` outside `REQ`; stale responses are dropped.
  - `ins_ack` outside `VALID`.
- **PC update:** PC changes only on an accept edge or on reset. `ins_addr` therefore stays stable for the whole `REQ`+`VALID` window, which keeps the combinational next-PC result coherent.
- **Arithmetic:** 32-bit. `retire_cnt` wraps from `32'hFFFF_FFFF` to 0 with no flag. The PC is loaded verbatim apart from the alignment rule in Configuration.

## Timing
- **Reset values (asynchronous, immediate on `rst_n`=0):**
  - state = `IDLE`
  - `ins_addr` = `imem_addr` = `RESET_PC`
  - `imem_req` = 0
  - `ins_out` = 0
  - `ins_valid` = 0
  - `retire_cnt` = 0
  - `fetch_fault` = 0
- **First request:** `imem_req` first rises in the second cycle after `rst_n` deasserts (`IDLE` lasts one cycle).
- **Latency:**
  - `imem_ready` seen in `REQ` → `ins_valid` high on the next cycle.
  - `ins_ack` seen in `VALID` → new `ins_addr` and `imem_req` high on the next cycle.
  - Best-case throughput is one instruction per 2 cycles.
- **Simultaneous events:** `imem_ready` and `ins_ack` cannot act in the same state, so there is no conflict.
- **Reset mid-operation:** aborts any outstanding request or held instruction. A memory response after reset is ignored until the new `REQ`.
- **Outputs:** all outputs are registered or state-decoded; there is no combinational input→output path.

## Configuration
- **Macro:** `IFU_MISALIGN_TRAP_EN`.
- **Defined:** on an accept with `next_ins_addr[1:0]` ≠ 0:
  - `retire_cnt` increments.
  - PC is not updated.
  - State goes to `FAULT`; `fetch_fault` rises next cycle and stays high until reset.
- **Undefined:**
  - PC ← `{next_ins_addr[31:2], 2'b00}`; low bits are silently cleared.
  - There is no `FAULT` state.
  - `fetch_fault` is tied 0.

## Test plan
- **Reset and first fetch:** reset, release, `imem_ready`=1 always → `imem_req` rises 2nd cycle after release with `imem_addr`=`32'h0000_3000`; `ins_valid`=1 one cycle later with `ins_out`=`imem_rdata`; `retire_cnt`=0.
- **Sequential accept:** `next_ins_addr`=`ins_addr`+4, `ins_ack`=1 whenever valid → addresses `3000`, `3004`, `3008`…, one accept every 2 cycles; after 10 accepts `retire_cnt`=10.
- **Memory wait and decode stall:** `imem_ready` low 3 cycles → `imem_req` and `imem_addr` held 4 cycles. `ins_ack` low 5 cycles → `ins_out` and `ins_addr` stable, `retire_cnt` unchanged.
- **Branch/jump target:** on accept, `next_ins_addr`=`32'h0000_3100` → next `imem_addr`=`32'h0000_3100`. A spurious `imem_ready` in `VALID` and `ins_ack` in `REQ` have no effect.
- **Misalignment:** accept with `next_ins_addr`=`32'h0000_3006`.
  - Macro defined: `fetch_fault`=1, `imem_req` stays 0, `ins_addr` unchanged, `retire_cnt` incremented.
  - Macro undefined: next `imem_addr`=`32'h0000_3004`, `fetch_fault`=0.
- **Reset mid-flight:** assert `rst_n`=0 while in `VALID` with `retire_cnt`=7 → all outputs take reset values immediately; a late `imem_ready` pulse during `IDLE` is ignored.
